// File: rtl/d_input_conditioner.sv
// Synchronizer plus debounce FSM feeding the d input of d_ff_struct.
// Optional glitch counter: define D_INPUT_CONDITIONER_GLITCH_CNT_EN.
module d_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int GLITCH_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  output logic d_clean,
  output logic rise_pulse,
  output logic fall_pulse,
`ifdef D_INPUT_CONDITIONER_GLITCH_CNT_EN
  output logic stable,
  output logic [GLITCH_W-1:0] glitch_cnt
`else
  output logic stable
`endif
);

  typedef enum logic [1:0] {
    LOW,
    LOW_CHK,
    HIGH,
    HIGH_CHK
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign s = sync[SYNC_STAGES-1];

  // shift the raw level through the synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din_async};
    end
  end

  // debounce FSM; d_clean and pulses change only on clk edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOW;
      cnt        <= '0;
      d_clean    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      unique case (state)
        LOW: begin
          if (s) begin
            state <= LOW_CHK;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        LOW_CHK: begin
          if (!s) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state      <= HIGH;
            cnt        <= '0;
            d_clean    <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!s) begin
            state <= HIGH_CHK;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        HIGH_CHK: begin
          if (s) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state      <= LOW;
            cnt        <= '0;
            d_clean    <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign stable = (state == LOW) || (state == HIGH);

`ifdef D_INPUT_CONDITIONER_GLITCH_CNT_EN
  logic abort;

  assign abort = ((state == LOW_CHK) && !s) ||
                 ((state == HIGH_CHK) && s);

  // saturating count of aborted checks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_d_input_conditioner.sv
// Bench for d_input_conditioner: vector tables through a scoreboard.
// Glitch counter checks run when the feature macro is defined.
module tb_d_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic din_async;
  logic d_clean;
  logic rise_pulse;
  logic fall_pulse;
  logic stable;
`ifdef D_INPUT_CONDITIONER_GLITCH_CNT_EN
  logic [1:0] glitch_cnt;
`endif

  d_input_conditioner #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8),
    .GLITCH_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din_async(din_async),
    .d_clean(d_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
`ifdef D_INPUT_CONDITIONER_GLITCH_CNT_EN
    .stable(stable),
    .glitch_cnt(glitch_cnt)
`else
    .stable(stable)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       din;
    logic       d;
    logic       r;
    logic       f;
    logic       st;
    logic [1:0] g;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   row   = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic din, input logic d,
                     input logic r, input logic f,
                     input logic st, input int g);
    vec_t v;
    v.din = din;
    v.d   = d;
    v.r   = r;
    v.f   = f;
    v.st  = st;
    v.g   = 2'(g);
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, " d_clean"}, int'(d_clean), int'(e.d));
    chk({tag, " rise"}, int'(rise_pulse), int'(e.r));
    chk({tag, " fall"}, int'(fall_pulse), int'(e.f));
    chk({tag, " stable"}, int'(stable), int'(e.st));
`ifdef D_INPUT_CONDITIONER_GLITCH_CNT_EN
    chk({tag, " glitch"}, int'(glitch_cnt), int'(e.g));
`endif
  endtask

  task automatic run_tbl(input string nm);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      din_async = tbl[i].din;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      row++;
      check_outs($sformatf("%s[%0d]", nm, i), e);
    end
    tbl.delete();
  endtask

  task automatic rise_rows(input int g);
    repeat (2) add(1, 0, 0, 0, 1, g);
    repeat (3) add(1, 0, 0, 0, 0, g);
    add(1, 1, 1, 0, 1, g);
    repeat (4) add(1, 1, 0, 0, 1, g);
  endtask

  task automatic fall_rows(input int g);
    repeat (2) add(0, 1, 0, 0, 1, g);
    repeat (3) add(0, 1, 0, 0, 0, g);
    add(0, 0, 0, 1, 1, g);
    repeat (4) add(0, 0, 0, 0, 1, g);
  endtask

  task automatic glitch_rows(input int g0, input int g1);
    repeat (2) add(1, 0, 0, 0, 1, g0);
    repeat (2) add(0, 0, 0, 0, 0, g0);
    repeat (3) add(0, 0, 0, 0, 1, g1);
  endtask

  // mid-cycle reset pulse, checked before any clk edge
  task automatic mid_reset(input string nm, input logic dv);
    vec_t z;
    z = '0;
    z.st = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check_outs(nm, z);
    din_async = dv;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    z = '0;
    z.st = 1'b1;
    rst = 1'b1;
    din_async = 1'b0;
    #8;
    check_outs("reset", z);
    #4;
    rst = 1'b0;

    rise_rows(0);
    run_tbl("rise");
    fall_rows(0);
    run_tbl("fall");
    glitch_rows(0, 1);
    run_tbl("glitch");
    rise_rows(1);
    run_tbl("rise2");
    chk("pre_reset d_clean", int'(d_clean), 1);

    mid_reset("async_rst", 1'b0);
    repeat (3) add(0, 0, 0, 0, 1, 0);
    run_tbl("idle");

    repeat (2) add(1, 0, 0, 0, 1, 0);
    repeat (2) add(1, 0, 0, 0, 0, 0);
    run_tbl("chk_pre");
    mid_reset("midchk_rst", 1'b1);
    rise_rows(0);
    run_tbl("post_rst_rise");
    fall_rows(0);
    run_tbl("fall2");

    mid_reset("sat_rst", 1'b0);
    for (int k = 0; k < 5; k++) begin
      glitch_rows(k < 3 ? k : 3, k < 2 ? k + 1 : 3);
    end
    run_tbl("sat");

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
